// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the redirect, memory request/response and decode
// handshake signals of the instruction fetch queue.
//   master : the fetch queue (drives requests, instructions, error flag)
//   slave  : the environment (core control, memory, decode)
interface fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        err_unexpected_resp;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
               mem_resp_data, inst_ready,
        output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
               err_unexpected_resp
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
               mem_resp_data, inst_ready,
        input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
               err_unexpected_resp
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage. Issues sequential 32-bit fetch
// requests to a variable-latency, in-order memory port, buffers responses in
// a DEPTH-entry FIFO and hands {inst, inst_pc} to decode. A redirect flushes
// the FIFO and marks every in-flight request as stale; stale responses are
// dropped before fetching restarts at the new PC.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : fetch_queue_if.master (redirect, mem req/resp, inst handshake,
//           sticky unexpected-response flag)
module fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h2000
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          err_q, err_d;

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic          has_credit, req_fire, unexpected, resp_ok, drop, enq, deq;
    logic [31:0]   redir_pc;

    // Credits cover both buffered and in-flight entries, so every response
    // that is not dropped always finds a free FIFO slot.
    assign has_credit = (int'(count_q) + int'(outst_q) < DEPTH) &&
                        (int'(outst_q) < MAX_OUTSTANDING);

    assign bus.mem_req_valid = !reset && (state_q == S_FETCH) && has_credit &&
                               !bus.redirect_valid;
    assign bus.mem_req_addr  = fetch_pc_q;

    assign req_fire   = bus.mem_req_valid && bus.mem_req_ready;
    // A response with a request firing in the same cycle answers that request.
    assign unexpected = bus.mem_resp_valid && (outst_q == '0) && !req_fire;
    assign resp_ok    = bus.mem_resp_valid && !unexpected;
    assign drop       = resp_ok && (drop_q != '0);
    assign enq        = resp_ok && !drop && !bus.redirect_valid;

    assign bus.inst_valid          = !reset && (count_q != '0);
    assign bus.inst                = inst_mem_q[rd_ptr_q];
    assign bus.inst_pc             = pc_mem_q[rd_ptr_q];
    assign bus.err_unexpected_resp = err_q;

    assign deq      = bus.inst_valid && bus.inst_ready;
    assign redir_pc = bus.redirect_pc & ~32'h3;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q | unexpected;

        case ({req_fire, resp_ok})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (drop)     drop_d     = drop_q - OW'(1);

        if (enq) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
        end
        if (deq) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Everything still in flight after this edge belongs to the old path.
        if (bus.redirect_valid) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            drop_d     = outst_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end

        state_d = (drop_d != '0) ? S_FLUSH : S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: count_q gates visibility.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem_q[wr_ptr_q] <= bus.mem_resp_data;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(enq && !deq && (count_q == CW'(DEPTH))));

endmodule
